// File: rtl/pc_seq_if.sv
// Sequencer <-> datapath bundle: IR fields and ALU/memory status in, enables and selects out.
// master = sequencer side, slave = datapath side.
interface pc_seq_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_rdy;
    logic [1:0] nPC_op;
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       dm_we;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] state;
    logic       illegal;

    modport master (
        input  op, funct, zero, mem_rdy,
        output nPC_op, pc_we, ir_we, rf_we, dm_we, alu_op, alu_src,
               ext_op, reg_dst, wd_sel, state, illegal
    );

    modport slave (
        output op, funct, zero, mem_rdy,
        input  nPC_op, pc_we, ir_we, rf_we, dm_we, alu_op, alu_src,
               ext_op, reg_dst, wd_sel, state, illegal
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle IF/DCD/EXE/MEM/WB sequencer; outputs are combinational from state and IR fields.
// Each instruction commits the PC once in its final state; S_MEM stalls on mem_rdy low.
module pc_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    pc_seq_if.master       bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_DCD = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
    } instr_t;

    state_t     state_q, state_d;
    instr_t     instr;
    logic [1:0] npc_c;
    logic       pc_we_c, ir_we_c, rf_we_c, dm_we_c, illegal_c;
    logic [2:0] alu_op_c;
    logic       alu_src_c, ext_op_c;
    logic [1:0] reg_dst_c, wd_sel_c;

    always_comb begin
        instr = I_ILL;
        case (bus.op)
            6'b000000: begin
                case (bus.funct)
                    6'b100001: instr = I_ADDU;
                    6'b100011: instr = I_SUBU;
                    6'b001000: instr = I_JR;
                    default:   instr = I_ILL;
                endcase
            end
            6'b001101: instr = I_ORI;
            6'b001111: instr = I_LUI;
            6'b100011: instr = I_LW;
            6'b101011: instr = I_SW;
            6'b000100: instr = I_BEQ;
            6'b000010: instr = I_J;
            6'b000011: instr = I_JAL;
            default:   instr = I_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        npc_c     = 2'b00;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        rf_we_c   = 1'b0;
        dm_we_c   = 1'b0;
        illegal_c = 1'b0;
        alu_op_c  = 3'b000;
        alu_src_c = 1'b0;
        ext_op_c  = 1'b0;
        reg_dst_c = 2'b00;
        wd_sel_c  = 2'b00;
        case (state_q)
            S_IF: begin
                ir_we_c = 1'b1;
                state_d = S_DCD;
            end
            S_DCD: begin
                case (instr)
                    I_J: begin
                        pc_we_c = 1'b1;
                        npc_c   = 2'b10;
                        state_d = S_IF;
                    end
                    I_JR: begin
                        pc_we_c = 1'b1;
                        npc_c   = 2'b11;
                        state_d = S_IF;
                    end
                    I_JAL: state_d = S_WB;
                    I_ILL: begin
                        pc_we_c   = 1'b1;
                        illegal_c = 1'b1;
                        state_d   = S_IF;
                    end
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                state_d = S_WB;
                case (instr)
                    I_SUBU: alu_op_c = 3'b001;
                    I_ORI: begin
                        alu_op_c  = 3'b010;
                        alu_src_c = 1'b1;
                    end
                    I_LUI: begin
                        alu_op_c  = 3'b011;
                        alu_src_c = 1'b1;
                    end
                    I_LW, I_SW: begin
                        alu_src_c = 1'b1;
                        ext_op_c  = 1'b1;
                        state_d   = S_MEM;
                    end
                    I_BEQ: begin
                        // zero is only meaningful here; both outcomes finish in this state
                        alu_op_c = 3'b001;
                        pc_we_c  = 1'b1;
                        npc_c    = bus.zero ? 2'b01 : 2'b00;
                        state_d  = S_IF;
                    end
                    default: alu_op_c = 3'b000;
                endcase
            end
            S_MEM: begin
                if (bus.mem_rdy) begin
                    if (instr == I_SW) begin
                        dm_we_c = 1'b1;
                        pc_we_c = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_IF;
                case (instr)
                    I_ADDU, I_SUBU: reg_dst_c = 2'b01;
                    I_LW:           wd_sel_c  = 2'b01;
                    I_JAL: begin
                        reg_dst_c = 2'b10;
                        wd_sel_c  = 2'b10;
                        npc_c     = 2'b10;
                    end
                    default: reg_dst_c = 2'b00;
                endcase
            end
            default: state_d = S_IF;
        endcase
    end

    // Reset masks everything combinationally so an aborted instruction cannot write.
    assign bus.nPC_op  = rst ? 2'b00 : npc_c;
    assign bus.pc_we   = pc_we_c   & ~rst;
    assign bus.ir_we   = ir_we_c   & ~rst;
    assign bus.rf_we   = rf_we_c   & ~rst;
    assign bus.dm_we   = dm_we_c   & ~rst;
    assign bus.illegal = illegal_c & ~rst;
    assign bus.alu_op  = rst ? 3'b000 : alu_op_c;
    assign bus.alu_src = alu_src_c & ~rst;
    assign bus.ext_op  = ext_op_c  & ~rst;
    assign bus.reg_dst = rst ? 2'b00 : reg_dst_c;
    assign bus.wd_sel  = rst ? 2'b00 : wd_sel_c;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized bench for pc_seq_ctrl against a per-instruction reference model
// (expected state path, commit select, write enables and ALU controls).
module tb_pc_seq_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pc_seq_if bus ();

    pc_seq_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Instruction classes of the reference model
    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LUI = 4, C_LW = 5,
                   C_SW = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_ILL = 10;

    task automatic encode(input int cls, output logic [5:0] o, output logic [5:0] f);
        logic [5:0] junk;
        junk = 6'($urandom);
        o = 6'h00;
        f = junk;
        case (cls)
            C_ADDU: f = 6'h21;
            C_SUBU: f = 6'h23;
            C_JR:   f = 6'h08;
            C_ORI:  o = 6'h0D;
            C_LUI:  o = 6'h0F;
            C_LW:   o = 6'h23;
            C_SW:   o = 6'h2B;
            C_BEQ:  o = 6'h04;
            C_J:    o = 6'h02;
            C_JAL:  o = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    o = 6'h3F;
                end else begin
                    o = 6'h00;
                    f = 6'h20;
                end
            end
        endcase
    endtask

    // Runs one instruction starting in its IF cycle (just after a rising edge) and
    // returns just after the rising edge that begins the next instruction's IF.
    task automatic run_instr(input int cls, input int stall, input logic zb);
        logic [5:0] o, f;
        int  exp_st[$];
        int  exp_npc, exp_rf, exp_rd, exp_wd, exp_dm, exp_ill;
        int  exp_alu, exp_src, exp_ext;
        int  cyc, n_rf, n_dm, n_ill, n_ir, got_npc, got_rd, got_wd;
        bit  done;

        encode(cls, o, f);
        exp_st = '{0, 1};
        if (cls == C_JAL) exp_st.push_back(4);
        if (cls inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ}) exp_st.push_back(2);
        if (cls inside {C_LW, C_SW})
            for (int i = 0; i <= stall; i++) exp_st.push_back(3);
        if (cls inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW}) exp_st.push_back(4);

        exp_npc = (cls == C_J || cls == C_JAL) ? 2 : (cls == C_JR) ? 3 :
                  (cls == C_BEQ && zb) ? 1 : 0;
        exp_rf  = (cls inside {C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_JAL}) ? 1 : 0;
        exp_rd  = (cls inside {C_ADDU, C_SUBU}) ? 1 : (cls == C_JAL) ? 2 : 0;
        exp_wd  = (cls == C_LW) ? 1 : (cls == C_JAL) ? 2 : 0;
        exp_dm  = (cls == C_SW) ? 1 : 0;
        exp_ill = (cls == C_ILL) ? 1 : 0;
        exp_alu = (cls inside {C_SUBU, C_BEQ}) ? 1 : (cls == C_ORI) ? 2 : (cls == C_LUI) ? 3 : 0;
        exp_src = (cls inside {C_ORI, C_LUI, C_LW, C_SW}) ? 1 : 0;
        exp_ext = (cls inside {C_LW, C_SW}) ? 1 : 0;

        bus.op = o;
        bus.funct = f;
        cyc = 0; done = 0; n_rf = 0; n_dm = 0; n_ill = 0; n_ir = 0;
        got_npc = -1; got_rd = -1; got_wd = -1;
        while (!done && cyc < 24) begin
            bus.zero = (cyc == 2) ? zb : 1'($urandom);
            if ((cls == C_LW || cls == C_SW) && cyc >= 3 && cyc <= 3 + stall)
                bus.mem_rdy = (cyc == 3 + stall);
            else
                bus.mem_rdy = 1'($urandom);
            @(negedge clk);
            check_val($sformatf("state[c%0d i%0d]", cls, cyc), int'(bus.state),
                      (cyc < exp_st.size()) ? exp_st[cyc] : -1);
            if (bus.ir_we) begin
                n_ir++;
                check_val("ir_we_cycle", cyc, 0);
            end
            if (bus.rf_we) begin
                n_rf++;
                got_rd = int'(bus.reg_dst);
                got_wd = int'(bus.wd_sel);
            end
            if (bus.dm_we)   n_dm++;
            if (bus.illegal) n_ill++;
            if (cyc == 2 && exp_st.size() > 2 && exp_st[2] == 2) begin
                check_val($sformatf("alu_op[c%0d]", cls), int'(bus.alu_op), exp_alu);
                check_val($sformatf("alu_src[c%0d]", cls), int'(bus.alu_src), exp_src);
                if (cls inside {C_ORI, C_LW, C_SW})
                    check_val($sformatf("ext_op[c%0d]", cls), int'(bus.ext_op), exp_ext);
            end
            if (bus.pc_we) begin
                done = 1;
                got_npc = int'(bus.nPC_op);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val($sformatf("cycles[c%0d]", cls), cyc, exp_st.size());
        check_val($sformatf("nPC_op[c%0d]", cls), got_npc, exp_npc);
        check_val($sformatf("ir_we_cnt[c%0d]", cls), n_ir, 1);
        check_val($sformatf("rf_we_cnt[c%0d]", cls), n_rf, exp_rf);
        check_val($sformatf("dm_we_cnt[c%0d]", cls), n_dm, exp_dm);
        check_val($sformatf("illegal_cnt[c%0d]", cls), n_ill, exp_ill);
        if (exp_rf == 1) begin
            check_val($sformatf("reg_dst[c%0d]", cls), got_rd, exp_rd);
            check_val($sformatf("wd_sel[c%0d]", cls), got_wd, exp_wd);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_state"}, int'(bus.state), 0);
        check_val({tag, "_enables"},
                  int'({bus.pc_we, bus.ir_we, bus.rf_we, bus.dm_we, bus.illegal}), 0);
        check_val({tag, "_selects"},
                  int'({bus.nPC_op, bus.alu_op, bus.alu_src, bus.ext_op, bus.reg_dst, bus.wd_sel}), 0);
    endtask

    // Release reset just after a rising edge so the following cycle is the first IF.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("post_rst_ir_we", int'(bus.ir_we), 1);
        check_val("post_rst_state", int'(bus.state), 0);
    endtask

    task automatic reset_mid_lw();
        logic [5:0] o, f;
        encode(C_LW, o, f);
        bus.op = o;
        bus.funct = f;
        bus.mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        check_val("mid_lw_in_mem", int'(bus.state), 3);
        #2;
        rst = 1'b1;
        #1;
        check_quiet("rst_async");
        @(negedge clk);
        check_quiet("rst_held");
        release_reset();
    endtask

    initial begin
        int cls, k;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.op = 6'h00;
        bus.funct = 6'h00;
        bus.zero = 1'b0;
        bus.mem_rdy = 1'b0;
        #12;
        check_quiet("reset");
        release_reset();

        run_instr(C_ADDU, 0, 1'b0);
        run_instr(C_BEQ, 0, 1'b1);
        run_instr(C_BEQ, 0, 1'b0);
        run_instr(C_LW, 3, 1'b0);
        run_instr(C_JAL, 0, 1'b0);
        run_instr(C_JR, 0, 1'b0);
        bus.op = 6'h3F;
        run_instr(C_ILL, 0, 1'b0);
        run_instr(C_SW, 2, 1'b0);
        reset_mid_lw();
        run_instr(C_ORI, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            cls = int'($urandom_range(0, 10));
            k   = int'($urandom_range(0, 4));
            run_instr(cls, k, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end
endmodule
